rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
- Write-side front end of the 32x32 register file.
- Merges results from two producers into the single register-file write port (rf_we/rf_a3/rf_wd3):
  - the single-cycle ALU pipeline, which cannot be back-pressured;
  - a long-latency memory/load unit with a valid/ready handshake.
- Memory results are buffered in a small FIFO and drained in write-port idle cycles.
- A starvation counter forces a FIFO drain when ALU traffic is continuous.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- DEPTH, 2, memory-result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles the FIFO may be non-empty without draining before alu_stall asserts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- alu_valid  in  1  ALU result present this cycle.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_wd  in  DATA_W  ALU result data.
- mem_valid  in  1  memory result offered.
- mem_ready  out  1  arbiter accepts a memory result this cycle.
- mem_rd  in  ADDR_W  memory destination register.
- mem_wd  in  DATA_W  memory result data.
- rf_we  out  1  register-file write enable (to WE3).
- rf_a3  out  ADDR_W  write address (to A3).
- rf_wd3  out  DATA_W  write data (to WD3).
- alu_stall  out  1  upstream must hold alu_valid low this cycle.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- err_drop  out  1  sticky: an ALU result was dropped.

Behaviour:
Reset (rst=1 at posedge):
- rf_we=0, rf_a3=0, rf_wd3=0.
- FIFO empty, fifo_count=0.
- Starve counter 0, alu_stall=0, err_drop=0.
- While rst=1, mem_ready=0.
- A reset mid-operation discards buffered entries and all in-flight state.

Memory handshake:
- mem_ready = (fifo_count < DEPTH) and not rst. Combinational from registered count.
- Transfer occurs when mem_valid & mem_ready at a posedge.
- mem_valid must hold and mem_rd/mem_wd must stay stable until the transfer.

Grant selection, evaluated per cycle in this priority order:
1. alu_stall=1 and FIFO non-empty: grant FIFO head.
2. alu_valid=1: grant ALU.
3. FIFO non-empty: grant FIFO head.
4. FIFO empty and a memory transfer occurs this cycle: bypass. Grant the incoming memory result directly; it is not enqueued.
5. Otherwise: no grant.

Outputs and latency:
- Outputs are registered; the write appears one cycle after grant.
- rf_we = 1 only if the granted entry has rd != 0.
- rd == 0 entries are consumed (popped or accepted) but produce rf_we=0.
- rf_a3/rf_wd3 are loaded with the granted entry. With no grant they hold their previous values and rf_we=0.

FIFO occupancy:
- Enqueue on a memory transfer that is not bypassed.
- Dequeue when the head is granted.
- A simultaneous enqueue and dequeue leaves fifo_count unchanged.
- Read/write pointers wrap modulo DEPTH.

Starvation and stall:
- Starve counter increments each cycle the FIFO is non-empty and not dequeued, saturating at STARVE_LIMIT.
- It clears on any dequeue or when the FIFO is empty.
- alu_stall is registered. It is 1 in the cycle after the counter reaches STARVE_LIMIT, and stays 1 until the cycle after a dequeue.
- If alu_valid=1 while alu_stall=1, the ALU result is discarded and err_drop is set. err_drop clears only on rst.

Ordering:
- No ordering is enforced between sources.
- Issue logic guarantees that an ALU and a memory result never target the same rd while both are in flight.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with alu_valid=1 -> rf_we=0, mem_ready=0, fifo_count=0, err_drop=0. After release, mem_ready=1.
2. ALU only: alu_valid=1, alu_rd=5, alu_wd=0xDEADBEEF at cycle N -> at N+1, rf_we=1, rf_a3=5, rf_wd3=0xDEADBEEF. Repeat with alu_rd=0 -> rf_we=0.
3. Bypass: FIFO empty, alu_valid=0, mem_valid=1, mem_rd=7, mem_wd=0x1234 -> same-cycle transfer, fifo_count stays 0. Next cycle rf_we=1, rf_a3=7, rf_wd3=0x1234.
4. Buffer and drain:
   - Cycles 0-1: ALU writes to x1, x2, with memory results to x10, x11 offered at the same time -> both enqueued, fifo_count=2, mem_ready=0.
   - Cycle 2: ALU idle -> x10 written at cycle 3 and x11 at cycle 4, in FIFO order. fifo_count returns to 0.
5. Starvation:
   - Setup: FIFO holds one entry; alu_valid=1 continuously with distinct rd.
   - Required: alu_stall asserts after STARVE_LIMIT=4 blocked cycles; the FIFO head is written in the stall cycle; alu_stall deasserts next cycle.
   - Repeat while driving alu_valid=1 during the stall -> err_drop=1 and stays set.
6. Full plus simultaneous push/pop: FIFO full (count=2), ALU idle, mem_valid=1 -> mem_ready=0, head pops, then mem_ready=1. Push and pop occur in the same cycle with count held at 1, and pointer wrap is checked over 8 entries.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
// Write-side front end of the register file: merges the unstallable ALU result stream
// and buffered memory/load results onto the single rf_we/rf_a3/rf_wd3 write port.
module rf_writeback_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [ADDR_W-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_wd,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_rd,
   input  logic [DATA_W-1:0]        mem_wd,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_a3,
   output logic [DATA_W-1:0]        rf_wd3,
   output logic                     alu_stall,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     err_drop
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

   logic [ADDR_W-1:0] fifo_rd_q [DEPTH];
   logic [ADDR_W-1:0] fifo_rd_d [DEPTH];
   logic [DATA_W-1:0] fifo_wd_q [DEPTH];
   logic [DATA_W-1:0] fifo_wd_d [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [SW-1:0]     starve_q, starve_d;
   logic              stall_q, stall_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] a3_q, a3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;

   logic              fifo_ne, mem_xfer, enq, deq;
   logic              grant_fifo, grant_alu, grant_byp, grant_any;
   logic [ADDR_W-1:0] sel_rd;
   logic [DATA_W-1:0] sel_wd;

   // Memory handshake: a result moves when mem_valid and mem_ready are both high at a
   // posedge; the producer holds mem_valid/mem_rd/mem_wd stable until that happens.
   assign mem_ready = !rst && (count_q < DEPTH_C);
   assign mem_xfer  = mem_valid && mem_ready;
   assign fifo_ne   = (count_q != '0);

   always_comb begin
      grant_fifo = 1'b0;
      grant_alu  = 1'b0;
      grant_byp  = 1'b0;
      // A stalled cycle always has a buffered entry, so the ALU can never win it.
      if (stall_q && fifo_ne)          grant_fifo = 1'b1;
      else if (alu_valid && !stall_q)  grant_alu  = 1'b1;
      else if (fifo_ne)                grant_fifo = 1'b1;
      else if (mem_xfer)               grant_byp  = 1'b1;
      grant_any = grant_fifo || grant_alu || grant_byp;
      enq = mem_xfer && !grant_byp;
      deq = grant_fifo;

      sel_rd = mem_rd;
      sel_wd = mem_wd;
      if (grant_fifo) begin
         sel_rd = fifo_rd_q[rd_ptr_q];
         sel_wd = fifo_wd_q[rd_ptr_q];
      end else if (grant_alu) begin
         sel_rd = alu_rd;
         sel_wd = alu_wd;
      end
   end

   always_comb begin
      fifo_rd_d = fifo_rd_q;
      fifo_wd_d = fifo_wd_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (enq) begin
         fifo_rd_d[wr_ptr_q] = mem_rd;
         fifo_wd_d[wr_ptr_q] = mem_wd;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      starve_d = starve_q;
      if (!fifo_ne || deq)          starve_d = '0;
      else if (starve_q != LIMIT_C) starve_d = starve_q + SW'(1);
      stall_d = (starve_d == LIMIT_C);
      err_d   = err_q || (alu_valid && stall_q);

      we_d  = grant_any && (sel_rd != '0);
      a3_d  = grant_any ? sel_rd : a3_q;
      wd3_d = grant_any ? sel_wd : wd3_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_rd_q[i] <= '0;
            fifo_wd_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
         err_q    <= 1'b0;
         we_q     <= 1'b0;
         a3_q     <= '0;
         wd3_q    <= '0;
      end else begin
         fifo_rd_q <= fifo_rd_d;
         fifo_wd_q <= fifo_wd_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         err_q     <= err_d;
         we_q      <= we_d;
         a3_q      <= a3_d;
         wd3_q     <= wd3_d;
      end
   end

   assign rf_we      = we_q;
   assign rf_a3      = a3_q;
   assign rf_wd3     = wd3_q;
   assign alu_stall  = stall_q;
   assign fifo_count = count_q;
   assign err_drop   = err_q;
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_rf_writeback_arbiter;
   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 5;
   localparam int DEPTH        = 2;
   localparam int STARVE_LIMIT = 4;

   logic              clk;
   logic              rst;
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_rd;
   logic [DATA_W-1:0] alu_wd;
   logic              mem_valid;
   logic              mem_ready;
   logic [ADDR_W-1:0] mem_rd;
   logic [DATA_W-1:0] mem_wd;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_a3;
   logic [DATA_W-1:0] rf_wd3;
   logic              alu_stall;
   logic [$clog2(DEPTH):0] fifo_count;
   logic              err_drop;

   rf_writeback_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_wd(alu_wd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wd(mem_wd),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
      .alu_stall(alu_stall), .fifo_count(fifo_count), .err_drop(err_drop)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard / reference model ----------------
   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   bit last_xfer;

   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic              m_we, m_stall, m_err;
   logic [ADDR_W-1:0] m_a3;
   logic [DATA_W-1:0] m_wd;
   int                m_starve;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // The model applies the arbitration rules to a plain queue of pending memory results.
   always @(posedge clk) begin
      logic [ADDR_W+DATA_W-1:0] g;
      bit granted, byp, popped, xfer;
      int pre;
      if (rst) begin
         exp_q.delete();
         m_we = 0; m_a3 = '0; m_wd = '0;
         m_starve = 0; m_stall = 0; m_err = 0;
      end else begin
         pre     = exp_q.size();
         xfer    = mem_valid && (pre < DEPTH);
         granted = 0; byp = 0; popped = 0; g = '0;
         if (m_stall && pre > 0) begin
            g = exp_q.pop_front(); granted = 1; popped = 1;
         end else if (alu_valid && !m_stall) begin
            g = {alu_rd, alu_wd}; granted = 1;
         end else if (pre > 0) begin
            g = exp_q.pop_front(); granted = 1; popped = 1;
         end else if (xfer) begin
            g = {mem_rd, mem_wd}; granted = 1; byp = 1;
         end
         if (xfer && !byp) exp_q.push_back({mem_rd, mem_wd});
         m_err = m_err || (alu_valid && m_stall);
         m_we  = granted && (g[ADDR_W+DATA_W-1:DATA_W] != 0);
         if (granted) begin
            m_a3 = g[ADDR_W+DATA_W-1:DATA_W];
            m_wd = g[DATA_W-1:0];
         end
         if (pre == 0 || popped) m_starve = 0;
         else if (m_starve < STARVE_LIMIT) m_starve++;
         m_stall = (m_starve == STARVE_LIMIT);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("rf_we", rf_we, m_we);
         check("rf_a3", rf_a3, m_a3);
         check("rf_wd3", rf_wd3, m_wd);
         check("alu_stall", alu_stall, m_stall);
         check("err_drop", err_drop, m_err);
         check("fifo_count", fifo_count, exp_q.size());
         check("mem_ready", mem_ready, (!rst && exp_q.size() < DEPTH));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      #2;
      last_xfer = mem_valid && mem_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input bit v, input int rd, input logic [DATA_W-1:0] wd);
      alu_valid = v;
      alu_rd    = ADDR_W'(rd);
      alu_wd    = wd;
   endtask

   task automatic mem(input bit v, input int rd, input logic [DATA_W-1:0] wd);
      mem_valid = v;
      mem_rd    = ADDR_W'(rd);
      mem_wd    = wd;
   endtask

   task automatic starve_setup(input int mrd);
      alu(1, 3, 32'h33); mem(1, mrd, 32'hC00 + mrd);
      tick();
      check("starve_count1", fifo_count, 1);
      mem(0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         alu(1, 3 + i, 32'h30 + i);
         tick();
         check("starve_stall", alu_stall, (i == 4));
      end
      check("starve_alu_last", rf_a3, 7);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int alu_pct, mem_pct;
      int pct_tab[6];
      pct_tab = '{90, 50, 100, 20, 70, 95};
      rst = 1'b1;
      alu(1, 5, 32'h5555); mem(0, 0, 0);

      // Reset holds everything idle even with ALU traffic presented.
      tick();
      chk_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         check("rst_we", rf_we, 0);
         check("rst_ready", mem_ready, 0);
         check("rst_count", fifo_count, 0);
         check("rst_err", err_drop, 0);
         if (i == 0) tick();
      end
      rst = 1'b0; alu(0, 0, 0);
      #1;
      check("rel_ready", mem_ready, 1);

      // ALU only
      alu(1, 5, 32'hDEADBEEF);
      tick();
      check("alu_we", rf_we, 1);
      check("alu_a3", rf_a3, 5);
      check("alu_wd", rf_wd3, 32'hDEADBEEF);
      alu(1, 0, 32'h55);
      tick();
      check("alu_x0_we", rf_we, 0);
      alu(0, 0, 0);

      // Bypass
      mem(1, 7, 32'h1234);
      tick();
      check("byp_xfer", last_xfer, 1);
      check("byp_count", fifo_count, 0);
      check("byp_we", rf_we, 1);
      check("byp_a3", rf_a3, 7);
      check("byp_wd", rf_wd3, 32'h1234);

      // Buffer and drain
      alu(1, 1, 32'h11); mem(1, 10, 32'hA10);
      tick();
      check("buf_a3_0", rf_a3, 1);
      check("buf_count_0", fifo_count, 1);
      alu(1, 2, 32'h22); mem(1, 11, 32'hA11);
      tick();
      check("buf_a3_1", rf_a3, 2);
      check("buf_count_1", fifo_count, 2);
      check("buf_ready_full", mem_ready, 0);
      alu(0, 0, 0); mem(0, 0, 0);
      tick();
      check("drain_a3_10", rf_a3, 10);
      check("drain_wd_10", rf_wd3, 32'hA10);
      tick();
      check("drain_a3_11", rf_a3, 11);
      check("drain_count", fifo_count, 0);

      // Starvation with a well-behaved upstream
      starve_setup(12);
      alu(0, 0, 0);
      tick();
      check("stall_head_a3", rf_a3, 12);
      check("stall_head_we", rf_we, 1);
      check("stall_release", alu_stall, 0);
      check("stall_count", fifo_count, 0);
      check("no_drop", err_drop, 0);

      // Starvation with an ALU result offered during the stall
      starve_setup(13);
      alu(1, 9, 32'h99);
      tick();
      check("drop_head_a3", rf_a3, 13);
      check("drop_err", err_drop, 1);
      alu(0, 0, 0);
      tick();
      check("drop_err_sticky", err_drop, 1);

      // Reset mid-operation discards buffered entries
      alu(1, 1, 32'h1); mem(1, 14, 32'hE);
      tick();
      alu(1, 2, 32'h2); mem(1, 15, 32'hF);
      tick();
      rst = 1'b1; alu(0, 0, 0); mem(0, 0, 0);
      tick();
      check("midrst_count", fifo_count, 0);
      check("midrst_err", err_drop, 0);
      check("midrst_we", rf_we, 0);
      rst = 1'b0;

      // Full FIFO, then simultaneous push/pop across pointer wrap
      alu(1, 1, 32'h1); mem(1, 10, 32'hA10);
      tick();
      alu(1, 2, 32'h2); mem(1, 11, 32'hA11);
      tick();
      check("full_count", fifo_count, 2);
      check("full_ready", mem_ready, 0);
      alu(0, 0, 0); mem(1, 20, 32'h100);
      tick();
      check("full_no_xfer", last_xfer, 0);
      check("full_pop_a3", rf_a3, 10);
      check("full_pop_count", fifo_count, 1);
      check("full_ready_again", mem_ready, 1);
      tick();
      check("pp_first_a3", rf_a3, 11);
      check("pp_first_count", fifo_count, 1);
      for (int i = 1; i <= 8; i++) begin
         mem(1, 20 + i, 32'h100 + i);
         tick();
         check("wrap_a3", rf_a3, 20 + i - 1);
         check("wrap_wd", rf_wd3, 32'h100 + i - 1);
         check("wrap_count", fifo_count, 1);
      end
      mem(0, 0, 0);
      tick();
      check("wrap_last_a3", rf_a3, 28);
      check("wrap_empty", fifo_count, 0);

      // Randomized traffic, model-checked every cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         alu_pct = pct_tab[(c / 500) % 6];
         mem_pct = 30 + (c / 500) * 10;
         rst = ($urandom_range(0, 399) == 0);
         if (last_xfer) mem_valid = 1'b0;
         if (!mem_valid && $urandom_range(0, 99) < mem_pct)
            mem(1, $urandom_range(0, 31), $urandom);
         alu_valid = ($urandom_range(0, 99) < alu_pct);
         if (alu_stall && !(c >= 2000 && $urandom_range(0, 7) == 0)) alu_valid = 1'b0;
         alu_rd = ADDR_W'($urandom_range(0, 31));
         alu_wd = $urandom;
         tick();
      end
      rst = 1'b0; alu(0, 0, 0); mem(0, 0, 0);
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
